pipelined_adder: RTL and testbench

- Parametrised, pipelined multi-bit adder/subtractor; successor to the single-bit full-adder cell.
- Splits a WIDTH-bit add into STAGES slices, one per clock. The carry ripples between registered stages.
- Valid/ready handshakes on input and output: one operation per cycle throughput, with full backpressure.
- Used as the datapath adder wherever a long carry chain would limit clock frequency.

---
 rtl/pipelined_adder.sv | 132 +++++++++++++
 tb/tb_pipelined_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one SW-bit slice per stage, carry registered between stages.
// Latency: STAGES cycles from input transfer to output transfer; 1 op/cycle throughput.
// Backpressure: combinational ready chain; a stage loads when empty or when the next stage loads.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  // Stage registers: valid, partial result, operands (b pre-inverted), slice carry-out.
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic              r_c   [STAGES];
  logic              msb_c;

  // Next-state values and per-stage load enables.
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] n_v;
  logic [WIDTH-1:0]  n_sum [STAGES];
  logic [WIDTH-1:0]  n_a   [STAGES];
  logic [WIDTH-1:0]  n_b   [STAGES];
  logic              n_c   [STAGES];
  logic              n_msb;

  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic [WIDTH-1:0]  src_s;
  logic              src_c;
  logic [SW:0]       tmp;
  int                p;

  // Slice arithmetic for every stage plus the backward ready chain.
  always_comb begin
    n_v   = '0;
    n_msb = 1'b0;
    ld    = '0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    src_c = 1'b0;
    tmp   = '0;
    p     = 0;
    for (int k = 0; k < STAGES; k++) begin
      n_sum[k] = '0;
      n_a[k]   = '0;
      n_b[k]   = '0;
      n_c[k]   = 1'b0;
    end

    for (int k = 0; k < STAGES; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        src_a  = a;
        src_b  = sub ? ~b : b;
        src_s  = '0;
        src_c  = sub ? 1'b1 : cin;
        n_v[k] = in_valid;
      end else begin
        src_a  = r_a[p];
        src_b  = r_b[p];
        src_s  = r_sum[p];
        src_c  = r_c[p];
        n_v[k] = vld[p];
      end
      tmp = {1'b0, src_a[k*SW +: SW]} + {1'b0, src_b[k*SW +: SW]} + {{SW{1'b0}}, src_c};
      n_sum[k]            = src_s;
      n_sum[k][k*SW +: SW] = tmp[SW-1:0];
      n_a[k]              = src_a;
      n_b[k]              = src_b;
      n_c[k]              = tmp[SW];
      // Carry into the MSB recovered from the MSB sum bit and its operand bits.
      if (k == L) n_msb = tmp[SW-1] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1];
    end

    ld[L] = !vld[L] || out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      ld[k] = !vld[k] || ld[k+1];
    end
  end

  // Advance each stage when it may load; data only captured for valid ops so outputs hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      msb_c <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld[k] <= n_v[k];
          if (n_v[k]) begin
            r_sum[k] <= n_sum[k];
            r_a[k]   <= n_a[k];
            r_b[k]   <= n_b[k];
            r_c[k]   <= n_c[k];
          end
        end
      end
      if (ld[L] && n_v[L]) msb_c <= n_msb;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[L];
  assign sum       = r_sum[L];
  assign cout      = r_c[L];
  assign ovf       = msb_c ^ r_c[L];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: arithmetic vectors, latency, backpressure, async reset.
// Inputs driven on the falling edge, outputs sampled #1 later, DUT captures on the rising edge.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single operation through an idle pipeline; checks result, latency and one-cycle valid pulse.
  task automatic run_single(input string tag, input logic [31:0] va, input logic [31:0] vb,
                            input logic vcin, input logic vsub,
                            input logic [31:0] esum, input logic ecout, input logic eovf);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = va; b = vb; cin = vcin; sub = vsub;
    #1;
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid && lat == 0) begin
        lat = i;
        check({tag, "_sum"},  {32'd0, sum},  {32'd0, esum});
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, ecout});
        check({tag, "_ovf"},  {63'd0, ovf},  {63'd0, eovf});
        break;
      end
    end
    check({tag, "_latency"}, lat, STAGES);
    @(negedge clk);
    #1;
    check({tag, "_pulse"}, {63'd0, out_valid}, 64'd0);
  endtask

  logic [31:0] exp_q[$];
  int          acc;
  int          dlv;
  bit          seen_stall;
  logic [31:0] e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       {32'd0, sum},       64'd0);
    check("rst_cout",      {63'd0, cout},      64'd0);
    check("rst_ovf",       {63'd0, ovf},       64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_single("add5p3",    32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
    run_single("ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_single("ovf_add",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_single("sub5m7",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_single("mid_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Stream of 8 ops with out_ready low in cycles 5..9.
    acc = 0; dlv = 0; seen_stall = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 40 && dlv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (acc < 8);
      a = acc + 1; b = acc + 1; cin = 1'b0; sub = 1'b0;
      #1;
      check("bp_in_ready", {63'd0, in_ready},
            {63'd0, ((acc - dlv) < STAGES) || out_ready});
      if (!in_ready) seen_stall = 1'b1;
      if (c >= 10) check("bp_throughput", {63'd0, out_valid}, 64'd1);
      if (out_valid && out_ready) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("bp_sum", {32'd0, sum}, {32'd0, e});
        dlv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(2 * (acc + 1));
        acc++;
      end
    end
    check("bp_stalled",   {63'd0, seen_stall}, 64'd1);
    check("bp_delivered", dlv, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h100 + i; b = 32'h1; cin = 1'b0; sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", {63'd0, out_valid}, 64'd0);
    check("mr_sum",       {32'd0, sum},       64'd0);
    check("mr_in_ready",  {63'd0, in_ready},  64'd1);
    check("mr_cout",      {63'd0, cout},      64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("mr_no_stale", {63'd0, out_valid}, 64'd0);
    end
    run_single("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
